tcdm_64_to_32_splitter: RTL and testbench
=========================================

// Module: tcdm_64_to_32_splitter
// PURPOSE
//  Converts one 64-bit TCDM master port (XBAR_TCDM_BUS_64 signal set) into a 32-bit TCDM master port.
//  Issues up to two sequential 32-bit sub-requests per 64-bit request: low word at A, high word at A+4.
//  Sits between a 64-bit initiator (e.g. DMA/FPU port) and the 32-bit TCDM crossbar.
// PARAMETERS
//  AW        32  address width, both sides
//  HI_OFFS   4   byte offset of the high sub-request from the aligned 64-bit address
// PORTS
//  clk_i         in   1   clock
//  rst_i         in   1   synchronous reset, active-high
//  s_req_i       in   1   64b request
//  s_add_i       in   AW  64b byte address; bits [2:0] ignored
//  s_wen_i       in   1   1=read, 0=write
//  s_wdata_i     in   64  write data
//  s_be_i        in   8   byte enables
//  s_gnt_o       out  1   64b grant
//  s_r_opc_o     out  1   response error (OR of sub-responses)
//  s_r_rdata_o   out  64  read data
//  s_r_valid_o   out  1   response valid, exactly 1 cycle after s_gnt_o
//  m_req_o       out  1   32b request
//  m_add_o       out  AW  32b address
//  m_wen_o       out  1   1=read, 0=write
//  m_wdata_o     out  32  write data
//  m_be_o        out  4   byte enables
//  m_gnt_i       in   1   32b grant
//  m_r_opc_i     in   1   32b response error
//  m_r_rdata_i   in   32  32b read data
//  m_r_valid_i   in   1   32b response valid, exactly 1 cycle after m_gnt_i
// BEHAVIOUR
//  - Protocol: req held with stable add/wen/wdata/be until gnt; response fixed 1-cycle latency after gnt.
//  - FSM {LO, HI}, reset -> LO. Per-request plan: need_lo, need_hi (see CONFIGURATION); reads need both.
//  - LO: m_req_o=s_req_i&need_lo, add={s_add[AW-1:3],3'b0}, wdata/be=low lane. On m_gnt_i:
//    need_hi -> HI, s_gnt_o=0; else s_gnt_o=1, stay LO.
//  - LO with !need_lo: behaves as HI for this request (high sub-request only, no state change).
//  - HI: m_req_o=1, add=aligned+HI_OFFS, wdata/be=high lane; s_gnt_o=m_gnt_i; on gnt -> LO.
//  - s_gnt_o is asserted only on the grant of the final sub-request; 64b response therefore
//    lands 1 cycle later, satisfying upstream latency with no extra buffering.
//  - Low read data/opc captured in lo_q on the m_r_valid_i that follows the low grant (in HI).
//  - s_r_valid_o = registered "final granted" flag & m_r_valid_i. rdata lanes: two-half ->
//    {m_r_rdata_i, lo_q}; low-only -> {32'h0, m_r_rdata_i}; high-only -> {m_r_rdata_i, 32'h0}.
//  - s_r_opc_o = m_r_opc_i | lo_opc_q (lo_opc_q=0 for single-half).
//  - m_r_valid_i following a non-final sub-grant never raises s_r_valid_o.
//  - Back-to-back: new s_req_i may be presented the cycle after s_gnt_o; LO sub-request of request
//    N+1 overlaps the response of request N with no bubble.
//  - Reset values: s_gnt_o=0, s_r_valid_o=0, s_r_opc_o=0, s_r_rdata_o=0, m_req_o=0, state=LO, lo_q=0.
//  - Reset in HI: abandons request, state->LO, pending flags cleared; responses in the reset
//    cycle are dropped. s_req_i dropped in HI (protocol violation): return to LO, no s_gnt_o.
//  - Address +HI_OFFS wraps modulo 2^AW.
// CONFIGURATION
//  TCDM64_SPLIT_BE_SKIP_EN defined: writes with s_be_i[7:4]==0 issue low only, s_be_i[3:0]==0 high only;
//   be==8'h00 write issues low only with be=4'h0. Not defined: need_lo=need_hi=1 for all requests.
// TESTING
//  Read A=0x100, gnt immediate -> m_add 0x100 then 0x104; s_gnt 2nd cycle; rdata {hi,lo} next cycle.
//  Write be=0xFF, wdata=0x11223344_55667788 -> m_wdata 0x55667788/be F, then 0x11223344/be F @0x104.
//  SKIP_EN, write be=0x0F @0x208 -> one sub-request @0x208, s_gnt same cycle; undefined -> two, hi be=0.
//  Read with m_gnt stalled 3 cycles in HI -> m_add/be held at 0x104; s_r_valid exactly once.
//  Low response opc=1, high opc=0 -> s_r_opc_o=1 with s_r_valid_o.
//  rst_i pulsed while in HI -> next cycle m_req_o=0, state LO; next request starts from low word.

Source files
------------

// File: rtl/tcdm_64_to_32_splitter.sv
// Splits one 64-bit TCDM request into up to two 32-bit sub-requests (low word, then high word).
// Optional macro TCDM64_SPLIT_BE_SKIP_EN: writes with an all-zero byte-enable half skip that half.
module tcdm_64_to_32_splitter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned HI_OFFS = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_req_i,
  input  logic [AW-1:0] s_add_i,
  input  logic          s_wen_i,
  input  logic [63:0]   s_wdata_i,
  input  logic [7:0]    s_be_i,
  output logic          s_gnt_o,
  output logic          s_r_opc_o,
  output logic [63:0]   s_r_rdata_o,
  output logic          s_r_valid_o,
  output logic          m_req_o,
  output logic [AW-1:0] m_add_o,
  output logic          m_wen_o,
  output logic [31:0]   m_wdata_o,
  output logic [3:0]    m_be_o,
  input  logic          m_gnt_i,
  input  logic          m_r_opc_i,
  input  logic [31:0]   m_r_rdata_i,
  input  logic          m_r_valid_i
);

  typedef enum logic {StLo, StHi} state_e;

  state_e        state_q, state_d;
  logic          need_lo, need_hi;
  logic          issue_hi;
  logic [AW-1:0] add_lo, add_hi;
  logic          fin_q, fin_d;
  logic          lo_wait_q, lo_wait_d;
  logic          two_q, two_d;
  logic          hi_only_q, hi_only_d;
  logic [31:0]   lo_q;
  logic          lo_opc_q;
  logic          unused_add;

  assign unused_add = ^s_add_i[2:0];

  // Per-request plan: which halves must be issued.
  always_comb begin
    need_lo = 1'b1;
    need_hi = 1'b1;
`ifdef TCDM64_SPLIT_BE_SKIP_EN
    if (!s_wen_i) begin
      if (s_be_i[7:4] == 4'h0) begin
        need_hi = 1'b0;
      end else if (s_be_i[3:0] == 4'h0) begin
        need_lo = 1'b0;
      end
    end
`endif
  end

  assign add_lo   = {s_add_i[AW-1:3], 3'b000};
  assign add_hi   = add_lo + AW'(HI_OFFS);
  // A high-only request in LO is issued exactly like the HI phase.
  assign issue_hi = (state_q == StHi) || !need_lo;

  always_comb begin
    state_d   = state_q;
    fin_d     = 1'b0;
    lo_wait_d = 1'b0;
    two_d     = two_q;
    hi_only_d = hi_only_q;
    m_req_o   = 1'b0;
    s_gnt_o   = 1'b0;
    m_wen_o   = s_wen_i;
    m_add_o   = issue_hi ? add_hi : add_lo;
    m_wdata_o = issue_hi ? s_wdata_i[63:32] : s_wdata_i[31:0];
    m_be_o    = issue_hi ? s_be_i[7:4] : s_be_i[3:0];
    if (!rst_i && s_req_i) begin
      m_req_o = 1'b1;
      if (m_gnt_i) begin
        if (issue_hi) begin
          s_gnt_o   = 1'b1;
          fin_d     = 1'b1;
          two_d     = (state_q == StHi);
          hi_only_d = (state_q == StLo);
          state_d   = StLo;
        end else if (need_hi) begin
          lo_wait_d = 1'b1;
          state_d   = StHi;
        end else begin
          s_gnt_o   = 1'b1;
          fin_d     = 1'b1;
          two_d     = 1'b0;
          hi_only_d = 1'b0;
        end
      end
    end else if (state_q == StHi) begin
      // Request withdrawn mid-transfer: abandon it.
      state_d = StLo;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StLo;
      fin_q     <= 1'b0;
      lo_wait_q <= 1'b0;
      two_q     <= 1'b0;
      hi_only_q <= 1'b0;
      lo_q      <= 32'h0;
      lo_opc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fin_q     <= fin_d;
      lo_wait_q <= lo_wait_d;
      two_q     <= two_d;
      hi_only_q <= hi_only_d;
      if (lo_wait_q && m_r_valid_i) begin
        lo_q     <= m_r_rdata_i;
        lo_opc_q <= m_r_opc_i;
      end
    end
  end

  assign s_r_valid_o = fin_q & m_r_valid_i & ~rst_i;

  always_comb begin
    s_r_rdata_o = 64'h0;
    s_r_opc_o   = 1'b0;
    if (s_r_valid_o) begin
      s_r_opc_o = m_r_opc_i | (two_q & lo_opc_q);
      if (two_q) begin
        s_r_rdata_o = {m_r_rdata_i, lo_q};
      end else if (hi_only_q) begin
        s_r_rdata_o = {m_r_rdata_i, 32'h0};
      end else begin
        s_r_rdata_o = {32'h0, m_r_rdata_i};
      end
    end
  end

endmodule

// File: tb/tb_tcdm_64_to_32_splitter.sv
// Bench for tcdm_64_to_32_splitter: directed vector table, hand sequences, and random traffic
// checked against a byte-addressed 64-bit memory model.
module tb_tcdm_64_to_32_splitter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_i, s_req_i, s_wen_i;
  logic [AW-1:0] s_add_i;
  logic [63:0]   s_wdata_i;
  logic [7:0]    s_be_i;
  logic          s_gnt_o, s_r_opc_o, s_r_valid_o;
  logic [63:0]   s_r_rdata_o;
  logic          m_req_o, m_wen_o;
  logic [AW-1:0] m_add_o;
  logic [31:0]   m_wdata_o;
  logic [3:0]    m_be_o;
  logic          m_gnt_i, m_r_opc_i, m_r_valid_i;
  logic [31:0]   m_r_rdata_i;

  always #5 clk = ~clk;

  tcdm_64_to_32_splitter #(.AW(AW), .HI_OFFS(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_wdata_i(s_wdata_i),
    .s_be_i(s_be_i), .s_gnt_o(s_gnt_o), .s_r_opc_o(s_r_opc_o), .s_r_rdata_o(s_r_rdata_o),
    .s_r_valid_o(s_r_valid_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_gnt_i(m_gnt_i), .m_r_opc_i(m_r_opc_i), .m_r_rdata_i(m_r_rdata_i),
    .m_r_valid_i(m_r_valid_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // 32-bit slave: word memory, optional directed response queue {opc, word}
  logic [31:0] rmem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [32:0] dir_q [$];
  bit          gnt_allow;

  logic        smp_mreq, smp_mwen, smp_sgnt, smp_svalid, smp_sopc, granted, last_opc;
  logic [31:0] smp_madd, smp_mwdata;
  logic [3:0]  smp_mbe;
  logic [63:0] smp_srdata;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000C0DE;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return init_word(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic void plan(input logic wen, input logic [7:0] be, output bit nl, output bit nh);
    nl = 1'b1;
    nh = 1'b1;
`ifdef TCDM64_SPLIT_BE_SKIP_EN
    if (!wen) begin
      if (be[7:4] == 4'h0) nh = 1'b0;
      else if (be[3:0] == 4'h0) nl = 1'b0;
    end
`endif
  endfunction

  // One clock: grant, sample combinational outputs, then present the 1-cycle-late response.
  task automatic tick();
    logic [31:0] w;
    logic        o;
    #1;
    m_gnt_i = m_req_o & gnt_allow;
    #1;
    smp_mreq = m_req_o;   smp_mwen = m_wen_o;     smp_madd = m_add_o;
    smp_mwdata = m_wdata_o; smp_mbe = m_be_o;     smp_sgnt = s_gnt_o;
    smp_svalid = s_r_valid_o; smp_sopc = s_r_opc_o; smp_srdata = s_r_rdata_o;
    granted = m_req_o & m_gnt_i;
    w = $urandom;
    o = $urandom_range(0, 1);
    if (granted) begin
      if (dir_q.size() > 0) begin
        {o, w} = dir_q.pop_front();
      end else begin
        o = ($urandom_range(0, 7) == 0);
        w = mem_rd(m_add_o);
        if (!m_wen_o) begin
          for (int i = 0; i < 4; i++) if (m_be_o[i]) w[8*i +: 8] = m_wdata_o[8*i +: 8];
          rmem[m_add_o] = w;
          w = $urandom;
        end
      end
      last_opc = o;
    end
    @(posedge clk);
    #1;
    m_r_valid_i = granted;
    m_r_rdata_i = w;
    m_r_opc_i   = o;
  endtask

  bit          rsp_due, rsp_read, rsp_opc;
  logic [63:0] rsp_rdata;

  task automatic rtick();
    tick();
    chk("rsp.valid", smp_svalid, rsp_due);
    if (rsp_due) begin
      chk("rsp.opc", smp_sopc, rsp_opc);
      if (rsp_read) chk("rsp.rdata", smp_srdata, rsp_rdata);
    end
    rsp_due = 1'b0;
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] add;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          nsub;
    logic [31:0] a0, a1;
    logic [35:0] db0, db1;
    logic [32:0] r0, r1;
    logic [63:0] rdata;
    logic        opc;
  } vec_t;

  function automatic vec_t mk(input logic wen, input logic [31:0] add, input logic [63:0] wdata,
                              input logic [7:0] be, input int nsub,
                              input logic [31:0] a0, input logic [35:0] db0,
                              input logic [31:0] a1, input logic [35:0] db1,
                              input logic [32:0] r0, input logic [32:0] r1,
                              input logic [63:0] rdata, input logic opc);
    vec_t v;
    v.wen = wen; v.add = add; v.wdata = wdata; v.be = be; v.nsub = nsub;
    v.a0 = a0; v.db0 = db0; v.a1 = a1; v.db1 = db1; v.r0 = r0; v.r1 = r1;
    v.rdata = rdata; v.opc = opc;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int k);
    string nm;
    nm = $sformatf("vec%0d", k);
    dir_q.delete();
    dir_q.push_back(v.r0);
    if (v.nsub == 2) dir_q.push_back(v.r1);
    gnt_allow = 1'b1;
    s_req_i = 1'b1; s_add_i = v.add; s_wen_i = v.wen; s_wdata_i = v.wdata; s_be_i = v.be;
    tick();
    chk({nm, ".req0"}, {smp_mreq, smp_mwen}, {1'b1, v.wen});
    chk({nm, ".add0"}, smp_madd, v.a0);
    chk({nm, ".db0"}, {smp_mwdata, smp_mbe}, v.db0);
    chk({nm, ".gnt0"}, smp_sgnt, v.nsub == 1);
    if (v.nsub == 2) begin
      tick();
      chk({nm, ".add1"}, smp_madd, v.a1);
      chk({nm, ".db1"}, {smp_mwdata, smp_mbe}, v.db1);
      chk({nm, ".gnt1"}, {smp_sgnt, smp_svalid}, 2'b10);
    end
    s_req_i = 1'b0;
    tick();
    chk({nm, ".valid"}, smp_svalid, 1'b1);
    chk({nm, ".rdata"}, smp_srdata, v.rdata);
    chk({nm, ".opc"}, smp_sopc, v.opc);
  endtask

  vec_t        vecs [8];
  int          nvalid, n, idx, cyc;
  bit          nl, nh, done, acc_opc;
  logic        r_wen;
  logic [31:0] r_add, al;
  logic [63:0] r_wd, r_exp;
  logic [7:0]  r_be;
  logic [31:0] ea [2];
  logic [31:0] ed [2];
  logic [3:0]  eb [2];

  initial begin
    vecs[0] = mk(1, 32'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2, 32'h100, {32'hCAFEF00D, 4'hF},
                 32'h104, {32'hDEADBEEF, 4'hF}, {1'b0, 32'hAAAA0001}, {1'b0, 32'hBBBB0002},
                 64'hBBBB0002_AAAA0001, 1'b0);
    vecs[1] = mk(0, 32'h200, 64'h11223344_55667788, 8'hFF, 2, 32'h200, {32'h55667788, 4'hF},
                 32'h204, {32'h11223344, 4'hF}, {1'b0, 32'h01010101}, {1'b0, 32'h02020202},
                 64'h02020202_01010101, 1'b0);
`ifdef TCDM64_SPLIT_BE_SKIP_EN
    vecs[2] = mk(0, 32'h208, 64'hA5A5A5A5_12345678, 8'h0F, 1, 32'h208, {32'h12345678, 4'hF},
                 32'h0, 36'h0, {1'b0, 32'h33}, 33'h0, 64'h00000000_00000033, 1'b0);
    vecs[5] = mk(0, 32'h300, 64'h87654321_0BADF00D, 8'hF0, 1, 32'h304, {32'h87654321, 4'hF},
                 32'h0, 36'h0, {1'b0, 32'h7}, 33'h0, 64'h00000007_00000000, 1'b0);
    vecs[6] = mk(0, 32'h400, 64'h1, 8'h00, 1, 32'h400, {32'h1, 4'h0},
                 32'h0, 36'h0, {1'b0, 32'h9}, 33'h0, 64'h00000000_00000009, 1'b0);
`else
    vecs[2] = mk(0, 32'h208, 64'hA5A5A5A5_12345678, 8'h0F, 2, 32'h208, {32'h12345678, 4'hF},
                 32'h20C, {32'hA5A5A5A5, 4'h0}, {1'b0, 32'h33}, {1'b0, 32'h44},
                 64'h00000044_00000033, 1'b0);
    vecs[5] = mk(0, 32'h300, 64'h87654321_0BADF00D, 8'hF0, 2, 32'h300, {32'h0BADF00D, 4'h0},
                 32'h304, {32'h87654321, 4'hF}, {1'b0, 32'h7}, {1'b0, 32'h8},
                 64'h00000008_00000007, 1'b0);
    vecs[6] = mk(0, 32'h400, 64'h1, 8'h00, 2, 32'h400, {32'h1, 4'h0},
                 32'h404, {32'h0, 4'h0}, {1'b0, 32'h9}, {1'b0, 32'hA},
                 64'h0000000A_00000009, 1'b0);
`endif
    vecs[3] = mk(1, 32'h10F, 64'h0, 8'h00, 2, 32'h108, 36'h0, 32'h10C, 36'h0,
                 {1'b1, 32'h11110000}, {1'b0, 32'h22220000}, 64'h22220000_11110000, 1'b1);
    vecs[4] = mk(1, 32'hFFFFFFFD, 64'h0, 8'hFF, 2, 32'hFFFFFFF8, {32'h0, 4'hF},
                 32'hFFFFFFFC, {32'h0, 4'hF}, {1'b0, 32'h5}, {1'b1, 32'h6},
                 64'h00000006_00000005, 1'b1);
    vecs[7] = mk(0, 32'h500, 64'hFFEEDDCC_BBAA9988, 8'h3C, 2, 32'h500, {32'hBBAA9988, 4'hC},
                 32'h504, {32'hFFEEDDCC, 4'h3}, {1'b0, 32'hC}, {1'b1, 32'hD},
                 64'h0000000D_0000000C, 1'b1);

    rst_i = 1'b1; s_req_i = 1'b0; s_add_i = '0; s_wen_i = 1'b1; s_wdata_i = '0; s_be_i = '0;
    m_gnt_i = 1'b0; m_r_opc_i = 1'b0; m_r_rdata_i = '0; m_r_valid_i = 1'b0; gnt_allow = 1'b1;
    rsp_due = 1'b0; rsp_read = 1'b0; rsp_opc = 1'b0; rsp_rdata = '0; last_opc = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("reset.outs", {smp_mreq, smp_sgnt, smp_svalid, smp_sopc}, 4'b0000);
    chk("reset.rdata", smp_srdata, 64'h0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Stall in the high phase: address/be held, exactly one response.
    dir_q.delete();
    dir_q.push_back({1'b0, 32'h0000AAAA});
    dir_q.push_back({1'b0, 32'h0000BBBB});
    nvalid = 0;
    s_req_i = 1'b1; s_add_i = 32'h100; s_wen_i = 1'b1; s_be_i = 8'hFF; s_wdata_i = '0;
    tick();
    nvalid += int'(smp_svalid);
    chk("stall.add0", smp_madd, 32'h100);
    gnt_allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvalid += int'(smp_svalid);
      chk("stall.hold", {smp_mreq, smp_madd, smp_mbe, smp_sgnt}, {1'b1, 32'h104, 4'hF, 1'b0});
    end
    gnt_allow = 1'b1;
    tick();
    nvalid += int'(smp_svalid);
    chk("stall.gnt", {smp_madd, smp_sgnt}, {32'h104, 1'b1});
    s_req_i = 1'b0;
    tick();
    nvalid += int'(smp_svalid);
    chk("stall.rdata", smp_srdata, 64'h0000BBBB_0000AAAA);
    tick();
    nvalid += int'(smp_svalid);
    chk("stall.nvalid", nvalid, 1);

    // Reset while in the high phase.
    dir_q.delete();
    s_req_i = 1'b1; s_add_i = 32'h600; s_wen_i = 1'b1; s_be_i = 8'hFF;
    tick();
    chk("rsthi.add0", smp_madd, 32'h600);
    gnt_allow = 1'b0;
    rst_i = 1'b1;
    tick();
    chk("rsthi.drop", smp_svalid, 1'b0);
    rst_i = 1'b0;
    s_req_i = 1'b0;
    tick();
    chk("rsthi.idle", {smp_mreq, smp_svalid}, 2'b00);
    dir_q.delete();
    dir_q.push_back({1'b0, 32'h77});
    dir_q.push_back({1'b0, 32'h88});
    gnt_allow = 1'b1;
    s_req_i = 1'b1; s_add_i = 32'h700;
    tick();
    chk("rsthi.lofirst", {smp_madd, smp_sgnt}, {32'h700, 1'b0});
    tick();
    chk("rsthi.hi", {smp_madd, smp_sgnt}, {32'h704, 1'b1});
    s_req_i = 1'b0;
    tick();
    chk("rsthi.rsp", {smp_svalid, smp_srdata}, {1'b1, 64'h00000088_00000077});

    // Random traffic against the 64-bit memory model.
    dir_q.delete();
    for (int t = 0; t < 300; t++) begin
      r_wen = 1'($urandom_range(0, 1));
      r_add = 32'h1000 + ($urandom_range(0, 31) << 3) + $urandom_range(0, 7);
      case ($urandom_range(0, 4))
        0:       r_be = 8'h0F;
        1:       r_be = 8'hF0;
        2:       r_be = 8'h00;
        3:       r_be = 8'hFF;
        default: r_be = 8'($urandom);
      endcase
      r_wd = {$urandom, $urandom};
      al = {r_add[31:3], 3'b000};
      plan(r_wen, r_be, nl, nh);
      n = 0;
      if (nl) begin ea[n] = al; ed[n] = r_wd[31:0]; eb[n] = r_be[3:0]; n++; end
      if (nh) begin ea[n] = al + 32'd4; ed[n] = r_wd[63:32]; eb[n] = r_be[7:4]; n++; end
      for (int i = 0; i < 8; i++) r_exp[8*i +: 8] = ref_rd(al + 32'(i));
      s_req_i = 1'b1; s_add_i = r_add; s_wen_i = r_wen; s_wdata_i = r_wd; s_be_i = r_be;
      idx = 0; acc_opc = 1'b0; cyc = 0; done = 1'b0;
      gnt_allow = ($urandom_range(0, 3) != 0);
      while (!done && cyc < 40) begin
        rtick();
        cyc++;
        chk("rnd.mreq", smp_mreq, 1'b1);
        if (granted) begin
          chk("rnd.add", smp_madd, ea[idx]);
          chk("rnd.sub", {smp_mwen, smp_mwdata, smp_mbe}, {r_wen, ed[idx], eb[idx]});
          chk("rnd.sgnt", smp_sgnt, idx == n - 1);
          acc_opc |= last_opc;
          if (idx == n - 1) done = 1'b1;
          else idx++;
        end else begin
          chk("rnd.sgnt_idle", smp_sgnt, 1'b0);
        end
        gnt_allow = ($urandom_range(0, 3) != 0);
      end
      if (!done) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd.timeout: got %0d grants, expected %0d", idx, n);
        break;
      end
      rsp_due = 1'b1; rsp_read = r_wen; rsp_opc = acc_opc; rsp_rdata = r_exp;
      if (!r_wen) begin
        for (int i = 0; i < 8; i++) if (r_be[i]) ref_mem[al + 32'(i)] = r_wd[8*i +: 8];
      end
      if ($urandom_range(0, 1) == 0) begin
        s_req_i = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 2)); i++) begin
          rtick();
          chk("idle.mreq", smp_mreq, 1'b0);
        end
      end
    end
    s_req_i = 1'b0;
    rtick();
    rtick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
